// File: rtl/ethernet_pkg.sv
// ethernet_pkg -- Ethernet II constants shared by the NetTLP receive path.
// No ports; imported by eth_decap_core.
package ethernet_pkg;

    localparam logic [15:0] ETH_P_IP      = 16'h0800;
    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage : ethernet_pkg

// File: rtl/ip_pkg.sv
// ip_pkg -- IPv4 constants shared by the NetTLP receive path.
// No ports; imported by eth_decap_core.
package ip_pkg;

    localparam logic [7:0] IPPROTO_UDP = 8'd17;
    // Version 4 with a 20-byte header; options are not supported.
    localparam logic [7:0] IPV4_VERIHL = 8'h45;

endpackage : ip_pkg

// File: rtl/nettlp_pkg.sv
// nettlp_pkg -- NetTLP framing: header beat count, header byte offsets,
// the PCIe-TX FIFO word and a header field capture helper.
// No ports; imported by eth_decap_core.
package nettlp_pkg;

    // Eth 14 + IPv4 20 + UDP 8 + NetTLP 6 = 48 B = 6 beats of 64 bits.
    localparam int unsigned HDR_BEATS = 6;

    // Byte offsets of the header fields inside the frame.
    localparam int unsigned OFF_DSTMAC = 0;
    localparam int unsigned OFF_ETYPE  = 12;
    localparam int unsigned OFF_VERIHL = 14;
    localparam int unsigned OFF_PROTO  = 23;
    localparam int unsigned OFF_DADDR  = 30;
    localparam int unsigned OFF_DPORT  = 36;
    localparam int unsigned OFF_SEQ    = 42;
    localparam int unsigned OFF_TSTAMP = 44;

    typedef struct packed {
        logic        err;
        logic        tlast;
        logic [7:0]  tkeep;
        logic [63:0] tdata;
    } PCIE_FIFO64_TX;

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] tstamp;
    } nettlp_hdr_t;

    // Overlays the bytes of a network-order field (up to 8 bytes, starting
    // at frame byte 'off') that live in beat 'beat' onto 'cur'. The first
    // frame byte of the field lands in the most significant byte.
    function automatic logic [63:0] hdr_field_capture(
        input logic [63:0] cur,
        input int unsigned off,
        input int unsigned nbytes,
        input int unsigned beat,
        input logic [63:0] tdata
    );
        logic [63:0] r;
        r = cur;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < nbytes && ((off + k) >> 3) == beat) begin
                r[8*(nbytes-1-k) +: 8] = tdata[8*((off + k) & 7) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage : nettlp_pkg

// File: rtl/eth_decap_core.sv
// eth_decap_core -- strips the Eth/IPv4/UDP/NetTLP header from a 64-bit
// AXI-Stream receive path and forwards the TLP payload, unregistered, into
// the PCIe-TX FIFO. Frames with a foreign header are dropped whole.
//
// Ports:
//   eth_clk, eth_rst_n           clock, asynchronous active-low reset
//   eth_rx_t*                    AXI-Stream input (tuser = bad frame, on tlast)
//   adapter_reg_srcip/srcmac     local IP / MAC address
//   wr_en, din, full             PCIe-TX FIFO write side
//   last_seq, last_tstamp        NetTLP seq/tstamp of the last accepted frame
//   cnt_rx, cnt_drop             saturating accepted / dropped frame counters
//
// Build option: define ETH_DECAP_DSTMAC_CHECK_EN to also require the
// destination MAC to be adapter_reg_srcmac or broadcast.
module eth_decap_core #(
    parameter int unsigned HDR_BEATS      = nettlp_pkg::HDR_BEATS,
    parameter logic [15:0] UDP_DPORT_BASE = 16'h3000,
    parameter int unsigned UDP_DPORT_SPAN = 16
) (
    input  logic                      eth_clk,
    input  logic                      eth_rst_n,
    input  logic                      eth_rx_tvalid,
    output logic                      eth_rx_tready,
    input  logic [63:0]               eth_rx_tdata,
    input  logic [7:0]                eth_rx_tkeep,
    input  logic                      eth_rx_tlast,
    input  logic                      eth_rx_tuser,
    input  logic [31:0]               adapter_reg_srcip,
    input  logic [47:0]               adapter_reg_srcmac,
    output logic                      wr_en,
    output nettlp_pkg::PCIE_FIFO64_TX din,
    input  logic                      full,
    output logic [15:0]               last_seq,
    output logic [31:0]               last_tstamp,
    output logic [15:0]               cnt_rx,
    output logic [15:0]               cnt_drop
);
    import nettlp_pkg::*;
    import ethernet_pkg::*;
    import ip_pkg::*;

    localparam int unsigned CNT_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HDR_BEATS - 1);

    // 17-bit window bounds so BASE+SPAN cannot wrap past 16'hFFFF.
    localparam logic [16:0] DPORT_LO = {1'b0, UDP_DPORT_BASE};
    localparam logic [16:0] DPORT_HI = DPORT_LO + 17'(UDP_DPORT_SPAN);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [15:0]      etype_q, etype_d;
    logic [7:0]       verihl_q, verihl_d;
    logic [7:0]       proto_q, proto_d;
    logic [31:0]      daddr_q, daddr_d;
    logic [15:0]      dport_q, dport_d;
    nettlp_hdr_t      tlp_hdr_q, tlp_hdr_d;    // header of the frame in flight
    nettlp_hdr_t      last_hdr_q, last_hdr_d;  // header of the last accepted frame
    logic [15:0]      cnt_rx_q, cnt_rx_d;
    logic [15:0]      cnt_drop_q, cnt_drop_d;
    // Holds tready low from reset until the first clock after release.
    logic             tready_en_q;

`ifdef ETH_DECAP_DSTMAC_CHECK_EN
    logic [47:0]      dstmac_q, dstmac_d;
    logic             dstmac_ok;
`else
    // Destination MAC is not examined in this build.
    logic             unused_srcmac;
    assign unused_srcmac = ^adapter_reg_srcmac;
`endif

    logic        xfer;
    logic        hdr_xfer;
    logic        hdr_accept;
    logic [31:0] beat_idx;

    assign eth_rx_tready = tready_en_q && ((state_q != PAYLOAD) || !full);
    assign xfer          = eth_rx_tvalid && eth_rx_tready;
    assign hdr_xfer      = xfer && ((state_q == IDLE) || (state_q == HDR));
    assign beat_idx      = 32'(beat_cnt_q);

    assign last_seq    = last_hdr_q.seq;
    assign last_tstamp = last_hdr_q.tstamp;
    assign cnt_rx      = cnt_rx_q;
    assign cnt_drop    = cnt_drop_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        etype_d    = etype_q;
        verihl_d   = verihl_q;
        proto_d    = proto_q;
        daddr_d    = daddr_q;
        dport_d    = dport_q;
        tlp_hdr_d  = tlp_hdr_q;
        last_hdr_d = last_hdr_q;
        cnt_rx_d   = cnt_rx_q;
        cnt_drop_d = cnt_drop_q;
        wr_en      = 1'b0;
        din        = '0;
`ifdef ETH_DECAP_DSTMAC_CHECK_EN
        dstmac_d   = dstmac_q;
`endif

        // Fields are captured from the current beat as well, so the accept
        // decision on the final header beat sees the complete header.
        if (hdr_xfer) begin
            etype_d          = 16'(hdr_field_capture(64'(etype_q), OFF_ETYPE, 2, beat_idx, eth_rx_tdata));
            verihl_d         = 8'(hdr_field_capture(64'(verihl_q), OFF_VERIHL, 1, beat_idx, eth_rx_tdata));
            proto_d          = 8'(hdr_field_capture(64'(proto_q), OFF_PROTO, 1, beat_idx, eth_rx_tdata));
            daddr_d          = 32'(hdr_field_capture(64'(daddr_q), OFF_DADDR, 4, beat_idx, eth_rx_tdata));
            dport_d          = 16'(hdr_field_capture(64'(dport_q), OFF_DPORT, 2, beat_idx, eth_rx_tdata));
            tlp_hdr_d.seq    = 16'(hdr_field_capture(64'(tlp_hdr_q.seq), OFF_SEQ, 2, beat_idx, eth_rx_tdata));
            tlp_hdr_d.tstamp = 32'(hdr_field_capture(64'(tlp_hdr_q.tstamp), OFF_TSTAMP, 4, beat_idx, eth_rx_tdata));
`ifdef ETH_DECAP_DSTMAC_CHECK_EN
            dstmac_d         = 48'(hdr_field_capture(64'(dstmac_q), OFF_DSTMAC, 6, beat_idx, eth_rx_tdata));
`endif
        end

        hdr_accept = (etype_d == ETH_P_IP)
                  && (verihl_d == IPV4_VERIHL)
                  && (proto_d == IPPROTO_UDP)
                  && (daddr_d == adapter_reg_srcip)
                  && ({1'b0, dport_d} >= DPORT_LO)
                  && ({1'b0, dport_d} < DPORT_HI);
`ifdef ETH_DECAP_DSTMAC_CHECK_EN
        dstmac_ok  = (dstmac_d == adapter_reg_srcmac) || (dstmac_d == ETH_BCAST_MAC);
        hdr_accept = hdr_accept && dstmac_ok;
`endif

        unique case (state_q)
            IDLE, HDR: begin
                if (hdr_xfer) begin
                    if (eth_rx_tlast) begin
                        // Runt, or header with no payload: nothing written.
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        cnt_drop_d = sat_inc16(cnt_drop_q);
                    end else if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = hdr_accept ? PAYLOAD : DROP;
                        beat_cnt_d = '0;
                    end else begin
                        state_d    = HDR;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    wr_en     = 1'b1;
                    din.tdata = eth_rx_tdata;
                    din.tkeep = eth_rx_tkeep;
                    din.tlast = eth_rx_tlast;
                    din.err   = eth_rx_tlast && eth_rx_tuser;
                    if (eth_rx_tlast) begin
                        state_d    = IDLE;
                        cnt_rx_d   = sat_inc16(cnt_rx_q);
                        last_hdr_d = tlp_hdr_q;
                    end
                end
            end
            DROP: begin
                if (xfer && eth_rx_tlast) begin
                    state_d    = IDLE;
                    cnt_drop_d = sat_inc16(cnt_drop_q);
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            etype_q     <= '0;
            verihl_q    <= '0;
            proto_q     <= '0;
            daddr_q     <= '0;
            dport_q     <= '0;
            tlp_hdr_q   <= '0;
            last_hdr_q  <= '0;
            cnt_rx_q    <= '0;
            cnt_drop_q  <= '0;
            tready_en_q <= 1'b0;
`ifdef ETH_DECAP_DSTMAC_CHECK_EN
            dstmac_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            etype_q     <= etype_d;
            verihl_q    <= verihl_d;
            proto_q     <= proto_d;
            daddr_q     <= daddr_d;
            dport_q     <= dport_d;
            tlp_hdr_q   <= tlp_hdr_d;
            last_hdr_q  <= last_hdr_d;
            cnt_rx_q    <= cnt_rx_d;
            cnt_drop_q  <= cnt_drop_d;
            tready_en_q <= 1'b1;
`ifdef ETH_DECAP_DSTMAC_CHECK_EN
            dstmac_q    <= dstmac_d;
`endif
        end
    end

endmodule : eth_decap_core

// File: tb/tb_eth_decap_core.sv
// tb_eth_decap_core -- directed frames against eth_decap_core with
// hand-built headers; FIFO writes and counters are compared to values the
// bench derives from the frames it sends.
module tb_eth_decap_core;

    localparam logic [31:0] MY_IP  = 32'hC0A8_0A01;
    localparam logic [47:0] MY_MAC = 48'h0200_0000_00AA;

    logic        eth_clk = 1'b0;
    logic        eth_rst_n = 1'b0;
    logic        eth_rx_tvalid = 1'b0;
    logic        eth_rx_tready;
    logic [63:0] eth_rx_tdata = '0;
    logic [7:0]  eth_rx_tkeep = '0;
    logic        eth_rx_tlast = 1'b0;
    logic        eth_rx_tuser = 1'b0;
    logic        wr_en;
    logic [73:0] din_w;
    logic        full = 1'b0;
    logic [15:0] last_seq;
    logic [31:0] last_tstamp;
    logic [15:0] cnt_rx;
    logic [15:0] cnt_drop;

    always #5 eth_clk = ~eth_clk;

    eth_decap_core #(
        .HDR_BEATS      (6),
        .UDP_DPORT_BASE (16'h3000),
        .UDP_DPORT_SPAN (16)
    ) dut (
        .eth_clk            (eth_clk),
        .eth_rst_n          (eth_rst_n),
        .eth_rx_tvalid      (eth_rx_tvalid),
        .eth_rx_tready      (eth_rx_tready),
        .eth_rx_tdata       (eth_rx_tdata),
        .eth_rx_tkeep       (eth_rx_tkeep),
        .eth_rx_tlast       (eth_rx_tlast),
        .eth_rx_tuser       (eth_rx_tuser),
        .adapter_reg_srcip  (MY_IP),
        .adapter_reg_srcmac (MY_MAC),
        .wr_en              (wr_en),
        .din                (din_w),
        .full               (full),
        .last_seq           (last_seq),
        .last_tstamp        (last_tstamp),
        .cnt_rx             (cnt_rx),
        .cnt_drop           (cnt_drop)
    );

    int n_vec = 0;
    int n_err = 0;
    int wait_cnt = 0;
    int stall_seen = 0;

    logic [7:0]  hb [48];
    logic [63:0] fr_d [$];
    logic [7:0]  fr_k [$];
    logic        fr_l [$];
    logic        fr_u [$];
    logic [73:0] got_q [$];
    logic [73:0] exp_q [$];
    logic [7:0]  frame_id = 8'h00;
    logic [15:0] cur_seq, exp_seq = '0;
    logic [31:0] cur_ts, exp_ts = '0;
    logic [15:0] exp_rx = '0, exp_drop = '0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(negedge eth_clk) if (wr_en === 1'b1) got_q.push_back(din_w);

    task automatic set_hdr(input logic [47:0] dmac, input logic [15:0] etype,
                           input logic [7:0] verihl, input logic [7:0] proto,
                           input logic [31:0] daddr, input logic [15:0] dport,
                           input logic [15:0] seq, input logic [31:0] ts);
        for (int i = 0; i < 48; i++) hb[i] = 8'(i * 3 + 1);
        for (int i = 0; i < 6; i++) hb[i] = dmac[8*(5-i) +: 8];
        hb[12] = etype[15:8];
        hb[13] = etype[7:0];
        hb[14] = verihl;
        hb[23] = proto;
        for (int i = 0; i < 4; i++) hb[30+i] = daddr[8*(3-i) +: 8];
        hb[36] = dport[15:8];
        hb[37] = dport[7:0];
        hb[42] = seq[15:8];
        hb[43] = seq[7:0];
        for (int i = 0; i < 4; i++) hb[44+i] = ts[8*(3-i) +: 8];
        cur_seq = seq;
        cur_ts  = ts;
    endtask

    // Builds 6 header beats followed by n_pay payload beats.
    task automatic make_frame(input int n_pay, input logic tuser);
        logic [63:0] d;
        logic        l;
        fr_d.delete(); fr_k.delete(); fr_l.delete(); fr_u.delete();
        frame_id = frame_id + 8'd1;
        for (int b = 0; b < 6; b++) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = hb[8*b + j];
            fr_d.push_back(d);
            fr_k.push_back(8'hFF);
            fr_l.push_back(n_pay == 0 && b == 5);
            fr_u.push_back(1'b0);
        end
        for (int p = 0; p < n_pay; p++) begin
            l = (p == n_pay - 1);
            fr_d.push_back({8'hC0, frame_id, 8'(p), 8'h5A, 32'h1357_9BDF ^ {4{8'(p)}}});
            fr_k.push_back(l ? 8'h1F : 8'hFF);
            fr_l.push_back(l);
            fr_u.push_back(l ? tuser : 1'b0);
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                              input logic l, input logic u, input int stall);
        bit ok;
        eth_rx_tvalid = 1'b1;
        eth_rx_tdata  = d;
        eth_rx_tkeep  = k;
        eth_rx_tlast  = l;
        eth_rx_tuser  = u;
        if (stall > 0) begin
            full = 1'b1;
            repeat (stall) begin
                @(negedge eth_clk);
                if (eth_rx_tready === 1'b0) stall_seen++;
            end
            @(posedge eth_clk);
            #1 full = 1'b0;
        end
        ok = 1'b0;
        for (int g = 0; g < 50; g++) begin
            @(negedge eth_clk);
            if (eth_rx_tready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            wait_cnt++;
        end
        if (!ok) chk("tready_timeout", 80'(ok), 80'(1));
        @(posedge eth_clk);
        #1;
        eth_rx_tvalid = 1'b0;
        eth_rx_tlast  = 1'b0;
        eth_rx_tuser  = 1'b0;
    endtask

    task automatic send_beats(input int from, input int to, input int stall_idx);
        for (int i = from; i <= to; i++)
            drive_beat(fr_d[i], fr_k[i], fr_l[i], fr_u[i], (i == stall_idx) ? 4 : 0);
    endtask

    task automatic expect_accept();
        for (int i = 6; i < fr_d.size(); i++)
            exp_q.push_back({fr_l[i] & fr_u[i], fr_l[i], fr_k[i], fr_d[i]});
        exp_rx  = exp_rx + 16'd1;
        exp_seq = cur_seq;
        exp_ts  = cur_ts;
    endtask

    task automatic expect_drop();
        exp_drop = exp_drop + 16'd1;
    endtask

    task automatic finish_frame(input string tag);
        repeat (3) @(posedge eth_clk);
        #1;
        chk({tag, "_nwr"}, 80'(got_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_din"}, 80'(got_q[i]), 80'(exp_q[i]));
        chk({tag, "_cnt_rx"}, 80'(cnt_rx), 80'(exp_rx));
        chk({tag, "_cnt_drop"}, 80'(cnt_drop), 80'(exp_drop));
        chk({tag, "_last_seq"}, 80'(last_seq), 80'(exp_seq));
        chk({tag, "_last_tstamp"}, 80'(last_tstamp), 80'(exp_ts));
        $display("[%0t] %s: writes=%0d cnt_rx=%0d cnt_drop=%0d last_seq=%h",
                 $time, tag, got_q.size(), cnt_rx, cnt_drop, last_seq);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready"}, 80'(eth_rx_tready), 80'(0));
        chk({tag, "_wr_en"}, 80'(wr_en), 80'(0));
        chk({tag, "_din"}, 80'(din_w), 80'(0));
        chk({tag, "_cnt_rx"}, 80'(cnt_rx), 80'(0));
        chk({tag, "_cnt_drop"}, 80'(cnt_drop), 80'(0));
        chk({tag, "_last_seq"}, 80'(last_seq), 80'(0));
        chk({tag, "_last_tstamp"}, 80'(last_tstamp), 80'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, and tready held low until the first clock after release.
        #12;
        check_reset_outputs("rst");
        @(negedge eth_clk);
        #1 eth_rst_n = 1'b1;
        #1 chk("rst_release_tready", 80'(eth_rx_tready), 80'(0));
        @(posedge eth_clk);
        #1 chk("post_rst_tready", 80'(eth_rx_tready), 80'(1));

        // Valid frame, dport 3005, three payload beats.
        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3005, 16'h1234, 32'hDEAD_BEEF);
        make_frame(3, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_accept();
        finish_frame("valid_3005");

        // IPv6 ethertype, 10 beats: all consumed, tready never low.
        set_hdr(MY_MAC, 16'h86DD, 8'h45, 8'd17, MY_IP, 16'h3005, 16'h2222, 32'h2222_2222);
        make_frame(4, 1'b0);
        wait_cnt = 0;
        send_beats(0, fr_d.size() - 1, -1);
        chk("ipv6_tready_waits", 80'(wait_cnt), 80'(0));
        expect_drop();
        finish_frame("ipv6_drop");

        // dport window edges.
        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3010, 16'h3333, 32'h3333_3333);
        make_frame(2, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_drop();
        finish_frame("dport_3010");

        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3000, 16'h0001, 32'h0000_0001);
        make_frame(2, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_accept();
        finish_frame("dport_3000");

        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h300F, 16'h000F, 32'h0000_000F);
        make_frame(1, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_accept();
        finish_frame("dport_300F");

        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h2FFF, 16'h2FFF, 32'h0000_2FFF);
        make_frame(1, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_drop();
        finish_frame("dport_2FFF");

        // full for 4 cycles on payload beat 2 (frame index 7).
        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3005, 16'h1234, 32'hDEAD_BEEF);
        make_frame(3, 1'b0);
        stall_seen = 0;
        wait_cnt = 0;
        send_beats(0, fr_d.size() - 1, 7);
        chk("stall_tready_low", 80'(stall_seen), 80'(4));
        chk("stall_extra_waits", 80'(wait_cnt), 80'(0));
        expect_accept();
        finish_frame("stall");

        // Runt with tlast on header beat 3, then a back-to-back valid frame.
        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3001, 16'h7777, 32'h7777_7777);
        make_frame(2, 1'b0);
        fr_l[3] = 1'b1;
        send_beats(0, 3, -1);
        expect_drop();
        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3002, 16'h5555, 32'h5555_AAAA);
        make_frame(2, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_accept();
        finish_frame("runt_b2b");

        // Bad-frame flag on the payload tlast.
        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3003, 16'h6666, 32'h6666_0000);
        make_frame(2, 1'b1);
        send_beats(0, fr_d.size() - 1, -1);
        expect_accept();
        finish_frame("tuser_err");

        // Header field mismatches.
        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, 32'hC0A8_0A02, 16'h3004, 16'h8001, 32'h8001);
        make_frame(2, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_drop();
        finish_frame("bad_daddr");

        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd6, MY_IP, 16'h3004, 16'h8002, 32'h8002);
        make_frame(2, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_drop();
        finish_frame("bad_proto");

        set_hdr(MY_MAC, 16'h0800, 8'h46, 8'd17, MY_IP, 16'h3004, 16'h8003, 32'h8003);
        make_frame(2, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_drop();
        finish_frame("bad_verihl");

        // Header only, tlast on the last header beat: dropped, seq untouched.
        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3004, 16'h9999, 32'h9999_9999);
        make_frame(0, 1'b0);
        send_beats(0, 5, -1);
        expect_drop();
        finish_frame("hdr_only");

        // Destination MAC: foreign unicast depends on the build option,
        // broadcast is always accepted.
        set_hdr(48'h0200_0000_0001, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3006, 16'hA001, 32'hA001);
        make_frame(2, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
`ifdef ETH_DECAP_DSTMAC_CHECK_EN
        expect_drop();
`else
        expect_accept();
`endif
        finish_frame("dmac_other");

        set_hdr(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3006, 16'hA002, 32'hA002);
        make_frame(2, 1'b0);
        send_beats(0, fr_d.size() - 1, -1);
        expect_accept();
        finish_frame("dmac_bcast");

        // Reset mid-frame: leftover beats form a runt and are dropped.
        set_hdr(MY_MAC, 16'h0800, 8'h45, 8'd17, MY_IP, 16'h3005, 16'hBBBB, 32'hBBBB_BBBB);
        make_frame(2, 1'b0);
        send_beats(0, 2, -1);
        eth_rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        @(negedge eth_clk);
        #1 eth_rst_n = 1'b1;
        @(posedge eth_clk);
        #1;
        exp_rx = '0; exp_drop = '0; exp_seq = '0; exp_ts = '0;
        send_beats(3, fr_d.size() - 1, -1);
        expect_drop();
        finish_frame("midrst_tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_eth_decap_core
